// File: rtl/sdc_host_master.sv
// sdc_host_master: hardware initiator for the byte-strobed SDC command channel.
// Optional build macro SDC_AUTOMOUNT_EN: announce IMG_SIZE0 for drive 0 with CMD4 out of reset.
module sdc_host_master #(
    parameter int          STROBE_GAP = 4,
    parameter int          POLL_MAX   = 65535,
    parameter logic [31:0] IMG_SIZE0  = 32'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        irq,
    output logic        iack,
    output logic        sdc_strobe,
    output logic        sdc_start,
    output logic [7:0]  sdc_dout,
    input  logic [7:0]  sdc_din,
    input  logic [31:0] base_lba0,
    input  logic [31:0] base_lba1,
    output logic        busy,
    output logic        err,
    output logic [31:0] last_sector
);
    localparam logic [7:0]  GAP_LAST  = 8'(STROBE_GAP - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

    typedef enum logic [3:0] {
        INIT, IDLE, ACK, ST_CMD, ST_RD, RW_CMD, RW_SECT, RW_POLL, FIN, MOUNT
    } state_t;

    state_t      state;
    logic [7:0]  gap;
    logic [2:0]  idx;
    logic [15:0] poll_cnt;
    logic [7:0]  mask;
    logic [23:0] sec;
    logic [31:0] lsec;
    logic [31:0] rsector;
    logic [31:0] lsec_next;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

    // The last sector byte is still on sdc_din when the CMD2 target is formed.
    assign rsector   = {sec, sdc_din};
    assign lsec_next = rsector + (mask[0] ? base_lba0 : base_lba1);

`ifndef SDC_AUTOMOUNT_EN
    logic unused_img;
    assign unused_img = ^IMG_SIZE0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= INIT;
            iack        <= 1'b0;
            sdc_strobe  <= 1'b0;
            sdc_start   <= 1'b0;
            sdc_dout    <= 8'h00;
            busy        <= 1'b0;
            err         <= 1'b0;
            last_sector <= 32'd0;
            gap         <= 8'd0;
            idx         <= 3'd0;
            poll_cnt    <= 16'd0;
        end else begin
            iack       <= 1'b0;
            sdc_strobe <= 1'b0;
            sdc_start  <= 1'b0;
            err        <= 1'b0;
            if (gap != 8'd0)
                gap <= gap - 8'd1;

            // gap==0 marks the last idle clock of a byte slot: response valid, next strobe may go out.
            case (state)
                INIT: begin
`ifdef SDC_AUTOMOUNT_EN
                    busy       <= 1'b1;
                    sdc_strobe <= 1'b1;
                    sdc_start  <= 1'b1;
                    sdc_dout   <= 8'h04;
                    gap        <= GAP_LAST;
                    idx        <= 3'd0;
                    state      <= MOUNT;
`else
                    state <= IDLE;
`endif
                end
`ifdef SDC_AUTOMOUNT_EN
                // Wrapper marks drive 0 mounted from the announced size (nonzero = mounted).
                MOUNT: if (gap == 8'd0) begin
                    if (idx != 3'd5) begin
                        sdc_strobe <= 1'b1;
                        sdc_dout   <= (idx == 3'd0) ? 8'h00 : word_byte(IMG_SIZE0, idx[1:0] - 2'd1);
                        gap        <= GAP_LAST;
                        idx        <= idx + 3'd1;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                IDLE: if (irq) begin
                    busy  <= 1'b1;
                    iack  <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    sdc_strobe <= 1'b1;
                    sdc_start  <= 1'b1;
                    sdc_dout   <= 8'h01;
                    gap        <= GAP_LAST;
                    state      <= ST_CMD;
                end
                ST_CMD: if (gap == 8'd0) begin
                    sdc_strobe <= 1'b1;
                    sdc_dout   <= 8'h00;
                    gap        <= GAP_LAST;
                    idx        <= 3'd0;
                    state      <= ST_RD;
                end
                ST_RD: if (gap == 8'd0) begin
                    if (idx == 3'd0)
                        mask <= sdc_din;
                    else
                        sec <= {sec[15:0], sdc_din};
                    if (idx != 3'd4) begin
                        sdc_strobe <= 1'b1;
                        sdc_dout   <= 8'h00;
                        gap        <= GAP_LAST;
                        idx        <= idx + 3'd1;
                    end else if (mask == 8'h00) begin
                        state <= FIN;
                    end else begin
                        lsec        <= lsec_next;
                        last_sector <= lsec_next;
                        sdc_strobe  <= 1'b1;
                        sdc_start   <= 1'b1;
                        sdc_dout    <= 8'h02;
                        gap         <= GAP_LAST;
                        state       <= RW_CMD;
                    end
                end
                RW_CMD: if (gap == 8'd0) begin
                    sdc_strobe <= 1'b1;
                    sdc_dout   <= lsec[31:24];
                    gap        <= GAP_LAST;
                    idx        <= 3'd1;
                    poll_cnt   <= 16'd0;
                    state      <= RW_SECT;
                end
                RW_SECT: if (gap == 8'd0) begin
                    sdc_strobe <= 1'b1;
                    gap        <= GAP_LAST;
                    if (idx != 3'd4) begin
                        sdc_dout <= word_byte(lsec, idx[1:0]);
                        idx      <= idx + 3'd1;
                    end else begin
                        sdc_dout <= 8'h00;
                        state    <= RW_POLL;
                    end
                end
                // Done: re-read STATUS, since a second drive's request raises no new irq.
                RW_POLL: if (gap == 8'd0) begin
                    if (sdc_din[0]) begin
                        if (poll_cnt == POLL_LAST) begin
                            err   <= 1'b1;
                            state <= FIN;
                        end else begin
                            poll_cnt   <= poll_cnt + 16'd1;
                            sdc_strobe <= 1'b1;
                            sdc_dout   <= 8'h00;
                            gap        <= GAP_LAST;
                        end
                    end else begin
                        sdc_strobe <= 1'b1;
                        sdc_start  <= 1'b1;
                        sdc_dout   <= 8'h01;
                        gap        <= GAP_LAST;
                        state      <= ST_CMD;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdc_host_master.sv
// tb_sdc_host_master: wrapper stub plus a transaction-level model of the expected byte stream.
`timescale 1ns/1ps
module tb_sdc_host_master;
    localparam int          G   = 3;
    localparam int          PM  = 8;
    localparam logic [31:0] IMG = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        irq = 1'b0;
    logic        iack, sdc_strobe, sdc_start, busy, err;
    logic [7:0]  sdc_dout;
    logic [7:0]  sdc_din = 8'h00;
    logic [31:0] base_lba0 = 32'd0;
    logic [31:0] base_lba1 = 32'd0;
    logic [31:0] last_sector;

    always #5 clk = ~clk;

    sdc_host_master #(.STROBE_GAP(G), .POLL_MAX(PM), .IMG_SIZE0(IMG)) dut (
        .clk(clk), .rstn(rstn), .irq(irq), .iack(iack),
        .sdc_strobe(sdc_strobe), .sdc_start(sdc_start), .sdc_dout(sdc_dout), .sdc_din(sdc_din),
        .base_lba0(base_lba0), .base_lba1(base_lba1),
        .busy(busy), .err(err), .last_sector(last_sector)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Request posted by the main sequence, consumed by the stub
    int          post_seq = 0;
    logic [1:0]  post_mask = 2'b00;
    logic [31:0] post_sec [2];
    int          post_bz [2];

    // Wrapper stub: raises irq, clears it on iack, answers STATUS / CORE_RW / polls
    int          post_seen = 0;
    logic [7:0]  st_cmd = 8'h00;
    int          st_n = 0;
    logic [1:0]  pend = 2'b00;
    int          busy_left = 0;
    int          drv = 0;
    logic [7:0]  rsp;
    logic [31:0] w;

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            irq = 1'b0; sdc_din = 8'h00; st_cmd = 8'h00; st_n = 0; pend = 2'b00; busy_left = 0;
        end else begin
            if (post_seq != post_seen) begin
                post_seen = post_seq;
                pend = post_mask;
                irq = 1'b1;
            end
            if (iack) irq = 1'b0;
            if (sdc_strobe) begin
                rsp = 8'h00;
                if (sdc_start) begin
                    st_cmd = sdc_dout;
                    st_n = 0;
                end else begin
                    st_n++;
                    drv = pend[0] ? 0 : 1;
                    if (st_cmd == 8'h01) begin
                        if (st_n == 1) rsp = {6'b0, pend};
                        else if (st_n <= 5) begin
                            w = (pend == 2'b00) ? 32'd0 : post_sec[drv];
                            rsp = w[8*(5-st_n) +: 8];
                        end
                    end else if (st_cmd == 8'h02) begin
                        if (st_n <= 4) begin
                            rsp = 8'hFF;
                            if (st_n == 4) begin
                                busy_left = post_bz[drv];
                                pend[drv] = 1'b0;
                            end
                        end else if (busy_left > 0) begin
                            busy_left--;
                            rsp = {7'($urandom), 1'b1};
                        end else begin
                            rsp = {7'($urandom), 1'b0};
                        end
                    end
                end
                sdc_din = rsp;
            end
        end
    end

    // Expected bus traffic as {start, byte}, plus expected counters
    logic [8:0]  expq [$];
    int          exp_iack = 0;
    int          exp_err = 0;
    logic [31:0] exp_last = 32'd0;

    // Bus monitor / compare state
    int          iack_cnt = 0;
    int          err_cnt = 0;
    int          txn_id = 0;
    logic        prev_busy = 1'b0;
    int          last_cyc = 0;
    int          last_txn = 0;
    logic        have_last = 1'b0;
    logic [7:0]  mon_cmd = 8'h00;
    int          mon_n = 0;
    int          mon_polls = 0;
    logic [31:0] seen_sect = 32'd0;
    logic [8:0]  e;

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) txn_id++;
            prev_busy = busy;
            if (sdc_start) check("start_needs_strobe", 32'(sdc_strobe), 32'd1);
            if (sdc_strobe) begin
                check("busy_during_strobe", 32'(busy), 32'd1);
                if (have_last) begin
                    if (last_txn == txn_id) check("strobe_spacing", cyc - last_cyc, G);
                    else check("strobe_gap_min", 32'(cyc - last_cyc >= G), 32'd1);
                end
                check("strobe_expected", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("bus_byte", 32'({sdc_start, sdc_dout}), 32'(e));
                end
                if (sdc_start) begin
                    mon_cmd = sdc_dout;
                    mon_n = 0;
                    if (sdc_dout == 8'h02) mon_polls = 0;
                end else begin
                    mon_n++;
                    if (mon_cmd == 8'h02 && mon_n <= 4) seen_sect = {seen_sect[23:0], sdc_dout};
                    if (mon_cmd == 8'h02 && mon_n > 4) mon_polls++;
                end
                last_cyc = cyc;
                last_txn = txn_id;
                have_last = 1'b1;
            end
            if (iack) iack_cnt++;
            if (err) begin
                err_cnt++;
                check("err_timing", cyc - last_cyc, G);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_status();
        expq.push_back(9'h101);
        repeat (5) expq.push_back(9'h000);
    endtask

    task automatic push_word(input logic [31:0] v);
        for (int i = 3; i >= 0; i--) expq.push_back({1'b0, v[8*i +: 8]});
    endtask

    task automatic push_mount();
`ifdef SDC_AUTOMOUNT_EN
        expq.push_back(9'h104);
        expq.push_back(9'h000);
        push_word(IMG);
`endif
    endtask

    // Serve lowest pending drive, poll, re-read STATUS until the mask is empty
    task automatic model_txn(input logic [1:0] m, input logic [31:0] s0, s1, b0, b1, input int bz0, bz1);
        logic [1:0]  rem;
        int          d, bz;
        logic [31:0] l;
        exp_iack++;
        push_status();
        rem = m;
        while (rem != 2'b00) begin
            d  = rem[0] ? 0 : 1;
            l  = (d == 0) ? s0 + b0 : s1 + b1;
            bz = (d == 0) ? bz0 : bz1;
            exp_last = l;
            expq.push_back(9'h102);
            push_word(l);
            if (bz >= PM) begin
                repeat (PM) expq.push_back(9'h000);
                exp_err++;
                rem = 2'b00;
            end else begin
                repeat (bz + 1) expq.push_back(9'h000);
                rem[d] = 1'b0;
                push_status();
            end
        end
    endtask

    task automatic post(input logic [1:0] m, input logic [31:0] s0, s1, input int bz0, bz1);
        post_mask = m;
        post_sec[0] = s0; post_sec[1] = s1;
        post_bz[0] = bz0; post_bz[1] = bz1;
        post_seq++;
    endtask

    task automatic run_txn(input logic [1:0] m, input logic [31:0] s0, s1, b0, b1, input int bz0, bz1);
        int t;
        base_lba0 = b0;
        base_lba1 = b1;
        model_txn(m, s0, s1, b0, b1, bz0, bz1);
        post(m, s0, s1, bz0, bz1);
        t = 0;
        while (!busy && t < 20) begin tick(1); t++; end
        check("busy_rise", 32'(busy), 32'd1);
        t = 0;
        while (busy && t < 3000) begin tick(1); t++; end
        check("busy_fall", 32'(busy), 32'd0);
        tick(2);
        check("queue_drained", expq.size(), 32'd0);
        check("last_sector", last_sector, exp_last);
        check("iack_count", iack_cnt, exp_iack);
        check("err_count", err_cnt, exp_err);
        expq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iack"}, 32'(iack), 32'd0);
        check({tag, "_strobe"}, 32'(sdc_strobe), 32'd0);
        check({tag, "_start"}, 32'(sdc_start), 32'd0);
        check({tag, "_dout"}, 32'(sdc_dout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_last_sector"}, last_sector, 32'd0);
    endtask

    task automatic release_reset();
        int t;
        push_mount();
        rstn = 1'b1;
        tick(2);
        t = 0;
        while (busy && t < 500) begin tick(1); t++; end
        check("init_quiet", 32'(busy), 32'd0);
        tick(2);
        check("init_queue_drained", expq.size(), 32'd0);
        expq.delete();
    endtask

    initial begin
        int i0, e0, t;
        logic [1:0]  m;
        logic [31:0] s0, s1, b0, b1;
        int          bz0, bz1;

        rstn = 1'b0;
        tick(4);
        check_reset_outputs("reset");
        release_reset();

        // Single drive 0 request: 0x10 + 0x800
        run_txn(2'b01, 32'h10, 32'h0, 32'h800, 32'h0, 0, 0);
        check("A_model_lsec", exp_last, 32'h810);
        check("A_last_sector", last_sector, 32'h0000_0810);
        check("A_sect_bytes", seen_sect, 32'h0000_0810);
        check("A_polls", mon_polls, 32'd1);

        // Both drives raised together: one iack, drive 0 then drive 1
        i0 = iack_cnt;
        run_txn(2'b11, 32'h100, 32'h200, 32'h10, 32'h20, 1, 2);
        check("B_one_iack", iack_cnt - i0, 32'd1);
        check("B_last_sector", last_sector, 32'h220);

        // Wrapper busy for three polls
        e0 = err_cnt;
        run_txn(2'b01, 32'h1234, 32'h0, 32'h100, 32'h0, 3, 0);
        check("C_polls", mon_polls, 32'd4);
        check("C_no_err", err_cnt - e0, 32'd0);

        // Wrapper busy forever: timeout after POLL_MAX busy reads
        e0 = err_cnt;
        run_txn(2'b01, 32'h55, 32'h0, 32'h1, 32'h0, PM + 100, 0);
        check("D_polls", mon_polls, 32'd8);
        check("D_one_err", err_cnt - e0, 32'd1);
        check("D_idle", 32'(busy), 32'd0);

        // LBA wrap on drive 1
        run_txn(2'b10, 32'h0, 32'h2, 32'h0, 32'hFFFF_FFFF, 0, 0);
        check("E_last_sector", last_sector, 32'h1);
        check("E_sect_bytes", seen_sect, 32'h0000_0001);

        // Randomized requests, including empty-mask and timeout cases
        for (int k = 0; k < 12; k++) begin
            m   = 2'($urandom_range(0, 3));
            s0  = $urandom; s1 = $urandom;
            b0  = $urandom; b1 = $urandom;
            bz0 = ($urandom_range(0, 7) == 0) ? PM + 2 : int'($urandom_range(0, 4));
            bz1 = int'($urandom_range(0, 4));
            run_txn(m, s0, s1, b0, b1, bz0, bz1);
        end

        // Reset in the middle of the sector bytes
        base_lba0 = 32'h4000;
        model_txn(2'b01, 32'h77, 32'h0, 32'h4000, 32'h0, 0, 0);
        post(2'b01, 32'h77, 32'h0, 0, 0);
        t = 0;
        while (!(mon_cmd == 8'h02 && mon_n == 2) && t < 500) begin tick(1); t++; end
        check("reach_rw_sect", 32'(mon_cmd == 8'h02 && mon_n == 2), 32'd1);
        rstn = 1'b0;
        tick(1);
        check_reset_outputs("midrst");
        expq.delete();
        exp_last = 32'd0;
        tick(2);
        release_reset();
        check("post_reset_last_sector", last_sector, 32'd0);
        run_txn(2'b01, 32'h30, 32'h0, 32'h100, 32'h0, 1, 0);
        check("F_last_sector", last_sector, 32'h130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
